// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the execute-stage integer divider.
//   div_state_t : divider FSM states
//   div_op_t    : operation flags latched at the start of an operation
//   INT64_MIN / INT32_MIN : most-negative values for the overflow special case
// -----------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic op_signed;
        logic op_rem;
        logic op_word;
    } div_op_t;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
// Request/response bundle between execute (master) and the divider (slave).
//   valid      : request, held with stable operands until data_ok
//   a, b       : dividend, divisor
//   op_signed  : signed (div/rem) vs unsigned
//   op_rem     : return remainder instead of quotient
//   op_word    : 32-bit W-variant
//   result     : quotient/remainder, meaningful while data_ok=1
//   data_ok    : one-cycle completion pulse
//   busy       : divider is not idle
// -----------------------------------------------------------------------------
interface divider_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            op_signed;
    logic            op_rem;
    logic            op_word;
    logic [XLEN-1:0] result;
    logic            data_ok;
    logic            busy;

    modport master (
        output valid, a, b, op_signed, op_rem, op_word,
        input  result, data_ok, busy
    );

    modport slave (
        input  valid, a, b, op_signed, op_rem, op_word,
        output result, data_ok, busy
    );
endinterface

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Restoring integer divider, one quotient bit per cycle, for the RV64M
// div/divu/rem/remu and divw/divuw/remw/remuw operations.
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : synchronous active-high reset
//   div_bus : divider_if slave modport (request, operands, result, data_ok, busy)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for valid; decodes operands and special cases
// ITER  | one restoring step per cycle, W cycles total
// FIX   | apply signs, select quotient/remainder, word sign-extension
// DONE  | data_ok pulse, result held; returns to IDLE unconditionally
// -----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic     i_clk,
    input  logic     i_reset,
    divider_if.slave div_bus
);

    localparam int CW = $clog2(XLEN);

    localparam logic [XLEN-1:0] MIN_DWORD = XLEN'(INT64_MIN);
    localparam logic [XLEN-1:0] MIN_WORD  = {{(XLEN-32){1'b1}}, INT32_MIN};

    div_state_t      r_state;
    div_state_t      w_state_nxt;

    div_op_t         r_op;
    logic            r_sign_q;
    logic            r_sign_r;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    div_op_t         w_op_in;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN-1:0] w_min;
    logic            w_sa;
    logic            w_sb;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_fix_res;
    logic [2*XLEN:0] w_step;

    logic            w_start;
    logic            w_special;
    logic            w_do_step;
    logic            w_do_fix;

    // Low word, sign- or zero-extended to XLEN.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        return {{(XLEN-32){sgn & v[31]}}, v};
    endfunction

    // W-variant results are always sign-extended from bit 31, unsigned ops included.
    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic word);
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // One restoring step: shift {rem, quo} left pulling in a dividend bit,
    // subtract the divisor when it fits and record a quotient 1.
    // rem is one bit wider than the divisor so the compare cannot overflow.
    function automatic logic [2*XLEN:0] div_step(
        input logic [XLEN:0]   rem,
        input logic [XLEN-1:0] quo,
        input logic            din,
        input logic [XLEN-1:0] dvs
    );
        logic [XLEN:0]   sh;
        logic [XLEN-1:0] q;
        sh = {rem[XLEN-1:0], din};
        q  = {quo[XLEN-2:0], 1'b0};
        if (sh >= {1'b0, dvs}) begin
            sh   = sh - {1'b0, dvs};
            q[0] = 1'b1;
        end
        return {sh, q};
    endfunction

    assign w_op_in = '{op_signed: div_bus.op_signed,
                       op_rem:    div_bus.op_rem,
                       op_word:   div_bus.op_word};

    // Operand decode, only consumed in IDLE.
    always_comb begin
        w_a_ext = div_bus.a;
        w_b_ext = div_bus.b;
        if (div_bus.op_word) begin
            w_a_ext = ext32(div_bus.a[31:0], div_bus.op_signed);
            w_b_ext = ext32(div_bus.b[31:0], div_bus.op_signed);
        end
        w_sa     = div_bus.op_signed & w_a_ext[XLEN-1];
        w_sb     = div_bus.op_signed & w_b_ext[XLEN-1];
        w_a_abs  = w_sa ? (~w_a_ext + 1'b1) : w_a_ext;
        w_b_abs  = w_sb ? (~w_b_ext + 1'b1) : w_b_ext;
        w_min    = div_bus.op_word ? MIN_WORD : MIN_DWORD;
        w_b_zero = (w_b_ext == '0);
        w_ovf    = div_bus.op_signed && (w_a_ext == w_min) && (w_b_ext == '1);

        if (w_b_zero) begin
            w_spec_res = div_bus.op_rem ? w_a_ext : '1;
        end else begin
            w_spec_res = div_bus.op_rem ? '0 : w_min;
        end
        w_spec_res = fmt_res(w_spec_res, div_bus.op_word);
    end

    // Sign fixup; the latched sign flags only matter for signed ops.
    always_comb begin
        w_quo_fix = (r_op.op_signed & r_sign_q) ? (~r_quo + 1'b1) : r_quo;
        w_rem_fix = (r_op.op_signed & r_sign_r) ? (~r_rem[XLEN-1:0] + 1'b1)
                                                : r_rem[XLEN-1:0];
        w_fix_res = fmt_res(r_op.op_rem ? w_rem_fix : w_quo_fix, r_op.op_word);
    end

    assign w_step = div_step(r_rem, r_quo, r_dvd[r_cnt], r_dvs);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_special   = 1'b0;
        w_do_step   = 1'b0;
        w_do_fix    = 1'b0;
        case (r_state)
            IDLE: begin
                if (div_bus.valid) begin
                    if (w_b_zero || w_ovf) begin
                        w_special   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                if (!div_bus.valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_do_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                if (!div_bus.valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_do_fix    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A still-high valid next cycle is a fresh request.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op     <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_start || w_special) begin
                r_op <= w_op_in;
            end
            if (w_start) begin
                r_sign_q <= w_sa ^ w_sb;
                r_sign_r <= w_sa;
                r_dvd    <= w_a_abs;
                r_dvs    <= w_b_abs;
                r_rem    <= '0;
                r_quo    <= '0;
                r_cnt    <= div_bus.op_word ? CW'(31) : CW'(XLEN-1);
            end
            if (w_special) begin
                r_result <= w_spec_res;
            end
            if (w_do_step) begin
                r_rem <= w_step[2*XLEN:XLEN];
                r_quo <= w_step[XLEN-1:0];
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_do_fix) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign div_bus.result  = r_result;
    assign div_bus.data_ok = (r_state == DONE);
    assign div_bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider: a behavioural model (plain SV arithmetic
// plus a latency rule) is compared against the DUT on every cycle, alongside
// directed operations with hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_divider;
    import divider_pkg::*;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    divider_if #(.XLEN(XLEN)) dif ();

    divider #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .div_bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {special_case, result} straight from the RV64M rules.
    function automatic logic [64:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input logic r, input logic w);
        logic [63:0] ua, ub, q, m, res;
        longint      sa, sb, smin;
        logic        sp;
        if (w) begin
            ua   = {32'd0, a[31:0]};
            ub   = {32'd0, b[31:0]};
            sa   = longint'($signed(a[31:0]));
            sb   = longint'($signed(b[31:0]));
            smin = longint'(64'hFFFF_FFFF_8000_0000);
        end else begin
            ua   = a;
            ub   = b;
            sa   = longint'(a);
            sb   = longint'(b);
            smin = longint'(INT64_MIN);
        end
        sp = 1'b1;
        if (ub == 64'd0) begin
            q = '1;
            m = s ? 64'(sa) : ua;
        end else if (s && sa == smin && sb == -1) begin
            q = 64'(smin);
            m = '0;
        end else begin
            sp = 1'b0;
            if (s) begin
                q = 64'(sa / sb);
                m = 64'(sa % sb);
            end else begin
                q = ua / ub;
                m = ua % ub;
            end
        end
        res = r ? m : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return {sp, res};
    endfunction

    // Model: idle / in-flight with a remaining-cycle budget / done pulse.
    logic        m_active = 1'b0;
    logic        m_dok    = 1'b0;
    int          m_left   = 0;
    logic [63:0] m_result = '0;
    logic [63:0] m_pend   = '0;

    always @(posedge clk) begin
        logic [64:0] rr;
        if (reset) begin
            m_active <= 1'b0;
            m_dok    <= 1'b0;
            m_left   <= 0;
            m_result <= '0;
        end else if (m_dok) begin
            m_dok <= 1'b0;
        end else if (!m_active) begin
            if (dif.valid) begin
                rr = ref_div(dif.a, dif.b, dif.op_signed, dif.op_rem, dif.op_word);
                if (rr[64]) begin
                    m_dok    <= 1'b1;
                    m_result <= rr[63:0];
                end else begin
                    m_active <= 1'b1;
                    m_left   <= (dif.op_word ? 34 : 66) - 1;
                    m_pend   <= rr[63:0];
                end
            end
        end else if (!dif.valid) begin
            m_active <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_active <= 1'b0;
                m_dok    <= 1'b1;
                m_result <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc data_ok", {64'd0, dif.data_ok}, {64'd0, m_dok});
            check("cyc busy", {64'd0, dif.busy}, {64'd0, (m_active | m_dok)});
            check("cyc result", {1'b0, dif.result}, {1'b0, m_result});
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic r, input logic w,
                          input logic chk, input logic [63:0] exp_res, input int exp_lat);
        int cyc;
        cyc = 0;
        dif.a = a; dif.b = b;
        dif.op_signed = s; dif.op_rem = r; dif.op_word = w;
        dif.valid = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!dif.data_ok && cyc < 200);
        check({name, " completed"}, {64'd0, dif.data_ok}, 65'd1);
        if (chk) begin
            check({name, " latency"}, 65'(cyc), 65'(exp_lat));
            check({name, " result"}, {1'b0, dif.result}, {1'b0, exp_res});
        end
        #1;
        dif.valid = 1'b0;
        @(posedge clk); #1;
        check({name, " pulse width"}, {64'd0, dif.data_ok}, 65'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [64:0] rr;
        int          cyc;

        reset = 1'b1;
        dif.valid = 1'b0; dif.a = '0; dif.b = '0;
        dif.op_signed = 1'b0; dif.op_rem = 1'b0; dif.op_word = 1'b0;

        // Pin the model itself against hand-computed values.
        rr = ref_div(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        check("model divu 100/7", rr, {1'b0, 64'd14});
        rr = ref_div(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b0);
        check("model rem -100/7", rr, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        rr = ref_div(64'd5, 64'd0, 1'b1, 1'b1, 1'b0);
        check("model rem 5/0", rr, {1'b1, 64'd5});
        rr = ref_div(64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0, 1'b0, 1'b1);
        check("model divuw", rr, {1'b0, 64'hFFFF_FFFF_8000_0000});

        repeat (3) @(posedge clk);
        #1;
        check("reset result", {1'b0, dif.result}, 65'd0);
        check("reset data_ok", {64'd0, dif.data_ok}, 65'd0);
        check("reset busy", {64'd0, dif.busy}, 65'd0);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #2;

        run_op("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, 64'd14, 66);
        run_op("remu 100/7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 1'b1, 64'd2, 66);
        run_op("div -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFF2, 66);
        run_op("rem -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("div 5/0", 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem 5/0", 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd5, 1);
        run_op("div min/-1", INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1,
               INT64_MIN, 1);
        run_op("rem min/-1", INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1,
               64'd0, 1);
        run_op("divuw", 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 34);
        run_op("divw -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("remw -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("divw min/-1", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0,
               1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divu 0/5", 64'd0, 64'd5, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 66);

        // Abort: valid dropped during cycle 20.
        dif.a = 64'd100; dif.b = 64'd7;
        dif.op_signed = 1'b0; dif.op_rem = 1'b0; dif.op_word = 1'b0;
        dif.valid = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        dif.valid = 1'b0;
        dif.a = 64'd55; dif.b = 64'd11;
        @(posedge clk); #1;
        check("abort busy", {64'd0, dif.busy}, 65'd0);
        check("abort data_ok", {64'd0, dif.data_ok}, 65'd0);
        check("abort result held", {1'b0, dif.result}, {1'b0, 64'd0});
        #1;
        repeat (3) @(posedge clk);
        #2;
        run_op("restart 9/3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3, 66);

        // Synchronous reset in the middle of ITER.
        dif.a = 64'd1000; dif.b = 64'd3;
        dif.valid = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset busy", {64'd0, dif.busy}, 65'd0);
        check("midreset data_ok", {64'd0, dif.data_ok}, 65'd0);
        check("midreset result", {1'b0, dif.result}, 65'd0);
        #1;
        reset = 1'b0;
        dif.valid = 1'b0;
        @(posedge clk); #2;

        // Back-to-back: valid held through DONE with new operands.
        dif.a = 64'd100; dif.b = 64'd7;
        dif.op_signed = 1'b0; dif.op_rem = 1'b0; dif.op_word = 1'b0;
        dif.valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!dif.data_ok && cyc < 200);
        check("b2b first latency", 65'(cyc), 65'd66);
        check("b2b first result", {1'b0, dif.result}, {1'b0, 64'd14});
        #1;
        dif.a = 64'd9; dif.b = 64'd3;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!dif.data_ok && cyc < 200);
        check("b2b second latency", 65'(cyc), 65'd67);
        check("b2b second result", {1'b0, dif.result}, {1'b0, 64'd3});
        #1;
        dif.valid = 1'b0;
        @(posedge clk); #2;

        // Mixed operations checked by the model only.
        for (int i = 0; i < 10; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (i % 4 == 0) rb = '0;
            if (i == 5) ra = INT64_MIN;
            run_op("mixed", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, '0, 0);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
